// File: rtl/pll_phase_ctrl.sv
// Dynamic-phase controller for the ECP5 EHXPLLL.
// Accepts step requests over valid/ready and generates the PHASESEL/PHASEDIR/
// PHASESTEP/PHASELOADREG sequence for them. It also filters the raw PLL lock
// and keeps a signed, wrapping phase-position counter for each output.
module pll_phase_ctrl #(
    parameter int NUM_OUTPUTS        = 4,
    parameter int STEP_W             = 8,
    parameter int SETUP_CYCLES       = 2,
    parameter int PULSE_CYCLES       = 4,
    parameter int SETTLE_CYCLES      = 8,
    parameter int LOCK_FILTER_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pll_locked,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_sel,
    input  logic                          req_dir,
    input  logic [STEP_W-1:0]             req_steps,
    output logic                          done,
    output logic                          done_err,
    output logic                          done_abort,
    output logic                          busy,
    output logic                          locked,
    output logic [NUM_OUTPUTS*STEP_W-1:0] phase_pos,
    output logic [1:0]                    phasesel,
    output logic                          phasedir,
    output logic                          phasestep,
    output logic                          phaseloadreg
);

    // Lock-filter counter: it must be able to hold LOCK_FILTER_CYCLES itself.
    localparam int LOCK_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_FILTER_CYCLES);

    // One shared phase timer counts 0 .. (longest phase - 1).
    localparam int TMR_MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > SETTLE_CYCLES) ? TMR_MAX_A : SETTLE_CYCLES;
    localparam int TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] SETUP_LAST  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

    // Compared against the 2-bit selector with a spare bit, so that a value of 4 fits.
    localparam logic [2:0] NUM_OUT_3 = 3'(NUM_OUTPUTS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        PULSE  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg;
    logic [STEP_W-1:0]  remain_reg;
    logic [LOCK_W-1:0]  lock_cnt_reg;
    logic [1:0]         phasesel_reg;
    logic               phasedir_reg;
    logic               phasestep_reg;
    logic               err_reg, err_next;
    logic               abort_reg, abort_next;
    logic               accept;
    logic               sel_ok;
    logic               step_done;
    logic [STEP_W-1:0]  pos_reg [NUM_OUTPUTS];

    // Lock filter: count consecutive high samples, saturate, and clear on any low.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_reg <= '0;
        end else if (!pll_locked) begin
            lock_cnt_reg <= '0;
        end else if (lock_cnt_reg != LOCK_MAX) begin
            lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
        end
    end

    assign locked = (lock_cnt_reg == LOCK_MAX);

    assign req_ready = (state_reg == IDLE) && locked;
    assign accept    = req_valid && req_ready;
    assign sel_ok    = ({1'b0, req_sel} < NUM_OUT_3);

    // A step counts as completed only on the last PULSE cycle, and only while lock is still good.
    assign step_done = (state_reg == PULSE) && locked && (timer_reg == PULSE_LAST);

    // Next-state logic. Losing lock in any active state goes straight to DONE as an abort.
    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        abort_next = abort_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    err_next   = !sel_ok;
                    abort_next = 1'b0;
                    if (!sel_ok || (req_steps == '0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                if (!locked) begin
                    state_next = DONE;
                    abort_next = 1'b1;
                end else if (timer_reg == SETUP_LAST) begin
                    state_next = PULSE;
                end
            end
            PULSE: begin
                if (!locked) begin
                    state_next = DONE;
                    abort_next = 1'b1;
                end else if (timer_reg == PULSE_LAST) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!locked) begin
                    state_next = DONE;
                    abort_next = 1'b1;
                end else if (timer_reg == SETTLE_LAST) begin
                    state_next = (remain_reg == '0) ? DONE : SETUP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer registers. The phase timer restarts whenever the state changes.
    // PHASESTEP is registered from the next state so that the PLL sees a clean flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            remain_reg    <= '0;
            err_reg       <= 1'b0;
            abort_reg     <= 1'b0;
            phasesel_reg  <= 2'd0;
            phasedir_reg  <= 1'b1;
            phasestep_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            err_reg       <= err_next;
            abort_reg     <= abort_next;
            phasestep_reg <= (state_next != PULSE);
            if ((state_next != state_reg) || (state_reg == IDLE)) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
            if (accept) begin
                phasesel_reg <= req_sel;
                phasedir_reg <= req_dir;
                remain_reg   <= req_steps;
            end else if (step_done) begin
                remain_reg <= remain_reg - STEP_W'(1);
            end
        end
    end

    // Per-output position counters. Each one moves by one, wrapping, when a step on its selector completes.
    generate
        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_pos
            always_ff @(posedge clk) begin
                if (reset) begin
                    pos_reg[gi] <= '0;
                end else if (step_done && (phasesel_reg == 2'(gi))) begin
                    if (phasedir_reg) begin
                        pos_reg[gi] <= pos_reg[gi] + STEP_W'(1);
                    end else begin
                        pos_reg[gi] <= pos_reg[gi] - STEP_W'(1);
                    end
                end
            end
            assign phase_pos[gi*STEP_W +: STEP_W] = pos_reg[gi];
        end
    endgenerate

    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign done_err     = done && err_reg;
    assign done_abort   = done && abort_reg;
    assign phasesel     = phasesel_reg;
    assign phasedir     = phasedir_reg;
    assign phasestep    = phasestep_reg;
    assign phaseloadreg = 1'b1;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl, built with three outputs so that selector 3 is out of range.
// Expected values come from the timing rules: the step period, the done cycle and the position arithmetic.
module tb_pll_phase_ctrl;

    localparam int NOUT = 3;
    localparam int SW   = 8;
    localparam int S    = 2;
    localparam int P    = 4;
    localparam int ST   = 8;
    localparam int LFC  = 1024;
    localparam int T    = S + P + ST;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pll_locked = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_sel = 2'd0;
    logic            req_dir = 1'b0;
    logic [SW-1:0]   req_steps = '0;
    logic            done, done_err, done_abort, busy, locked;
    logic [NOUT*SW-1:0] phase_pos;
    logic [1:0]      phasesel;
    logic            phasedir, phasestep, phaseloadreg;

    int n_cmp = 0;
    int n_err = 0;
    logic [SW-1:0] model_pos [NOUT];

    pll_phase_ctrl #(
        .NUM_OUTPUTS(NOUT), .STEP_W(SW), .SETUP_CYCLES(S), .PULSE_CYCLES(P),
        .SETTLE_CYCLES(ST), .LOCK_FILTER_CYCLES(LFC)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_dir(req_dir), .req_steps(req_steps),
        .done(done), .done_err(done_err), .done_abort(done_abort),
        .busy(busy), .locked(locked), .phase_pos(phase_pos),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
        .phaseloadreg(phaseloadreg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_positions(input string tag);
        for (int ch = 0; ch < NOUT; ch++) begin
            check($sformatf("%s_pos%0d", tag, ch), 32'(phase_pos[ch*SW +: SW]), 32'(model_pos[ch]));
        end
    endtask

    // Waits (bounded) until req_ready is high and returns the number of cycles waited.
    task automatic wait_ready(output int waited);
        waited = 0;
        while (!req_ready && waited < 3000) begin
            tick();
            waited++;
        end
    endtask

    // Issues one request and watches it until done.
    // drop_at > 0 pulls pll_locked low during that cycle, counted from the accept edge.
    task automatic do_req(input logic [1:0] sel, input logic dir, input logic [SW-1:0] steps, input int drop_at);
        int waited, cyc, done_cyc, low_cnt, falls, first_low, last_fall, completed;
        int exp_done;
        logic prev, d_err, d_abort, d_step, bad;
        bad = (sel >= NOUT);
        wait_ready(waited);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        tick();                       // accept edge; we are now in cycle 1
        req_valid = 1'b0;
        req_sel   = $urandom_range(0, 3);
        req_steps = SW'($urandom_range(0, 255));
        if (!bad) begin
            check("phasesel", 32'(phasesel), 32'(sel));
            check("phasedir", 32'(phasedir), 32'(dir));
        end
        cyc = 1; done_cyc = -1; low_cnt = 0; falls = 0; first_low = -1; last_fall = -1; prev = 1'b1;
        d_err = 1'b0; d_abort = 1'b0; d_step = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            if (drop_at > 0 && cyc == drop_at) pll_locked = 1'b0;
            if (drop_at > 0 && cyc == drop_at + 1) check("lock_fall", 32'(locked), 32'd0);
            if (!phasestep) begin
                low_cnt++;
                if (prev) begin
                    falls++;
                    last_fall = cyc;
                    if (first_low < 0) first_low = cyc;
                end
            end
            prev = phasestep;
            if (done) begin
                done_cyc = cyc;
                d_err = done_err;
                d_abort = done_abort;
                d_step = phasestep;
            end else begin
                tick();
                cyc++;
            end
        end
        if (drop_at > 0) begin
            exp_done = drop_at + 2;
            completed = 0;
            for (int k = 0; k < int'(steps); k++) if (S + P + k * T <= drop_at) completed++;
        end else begin
            exp_done = (bad || steps == 0) ? 1 : 1 + int'(steps) * T;
            completed = bad ? 0 : int'(steps);
            check("low_cycles", 32'(low_cnt), 32'(completed * P));
            check("pulse_count", 32'(falls), 32'(completed));
            if (completed > 0) begin
                check("first_pulse", 32'(first_low), 32'(S + 1));
                check("last_pulse", 32'(last_fall), 32'(S + 1 + (completed - 1) * T));
            end
        end
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("done_err", 32'(d_err), 32'(bad));
        check("done_abort", 32'(d_abort), 32'(drop_at > 0));
        check("step_at_done", 32'(d_step), 32'd1);
        if (!bad) begin
            if (dir) model_pos[sel] = model_pos[sel] + SW'(completed);
            else     model_pos[sel] = model_pos[sel] - SW'(completed);
        end
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(req_ready), 32'(drop_at <= 0));
        check_positions("req");
        $display("req sel=%0d dir=%0d steps=%0d drop=%0d -> done@%0d err=%0d abort=%0d pos=%h",
                 sel, dir, steps, drop_at, done_cyc, d_err, d_abort, phase_pos);
    endtask

    initial begin
        int waited;
        logic [1:0] rs;
        logic rd;
        logic [SW-1:0] rn;
        for (int ch = 0; ch < NOUT; ch++) model_pos[ch] = '0;

        // Reset values
        tick(); tick(); tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_done", 32'({done, done_err, done_abort}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pos", 32'(phase_pos), 32'd0);
        check("rst_phasesel", 32'(phasesel), 32'd0);
        check("rst_phasedir", 32'(phasedir), 32'd1);
        check("rst_phasestep", 32'(phasestep), 32'd1);
        check("rst_loadreg", 32'(phaseloadreg), 32'd1);
        reset = 1'b0;

        // Lock filter with a one-cycle glitch at count 500, then a clean lock.
        pll_locked = 1'b1;
        for (int k = 0; k < 500; k++) tick();
        check("lock_at_500", 32'(locked), 32'd0);
        pll_locked = 1'b0;
        tick();
        check("lock_glitch", 32'(locked), 32'd0);
        pll_locked = 1'b1;
        for (int k = 0; k < LFC - 1; k++) tick();
        check("lock_at_n_minus_1", 32'(locked), 32'd0);
        check("ready_unlocked", 32'(req_ready), 32'd0);
        tick();
        check("lock_at_n", 32'(locked), 32'd1);
        $display("lock filter: locked=%0d after %0d clean cycles", locked, LFC);

        // Directed requests
        do_req(2'd1, 1'b1, 8'd3, 0);
        do_req(2'd2, 1'b0, 8'd1, 0);
        do_req(2'd0, 1'b1, 8'd0, 0);
        do_req(2'd3, 1'b1, 8'd4, 0);

        // Random requests
        for (int i = 0; i < 10; i++) begin
            rs = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            rn = SW'($urandom_range(0, 5));
            do_req(rs, rd, rn, 0);
        end

        // Lock lost during the second PULSE of a five-step request.
        do_req(2'd0, 1'b1, 8'd5, S + T + 2);
        for (int k = 0; k < 5; k++) tick();
        check("ready_while_unlocked", 32'(req_ready), 32'd0);
        pll_locked = 1'b1;
        wait_ready(waited);
        check("relock_cycles", 32'(waited), 32'(LFC));
        $display("relock after %0d cycles", waited);

        // Reset asserted during SETTLE
        req_valid = 1'b1; req_sel = 2'd1; req_dir = 1'b1; req_steps = 8'd3;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();     // cycle 10, inside the first SETTLE
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_step", 32'(phasestep), 32'd1);
        check("mid_rst_pos", 32'(phase_pos), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_phasesel", 32'(phasesel), 32'd0);
        check("mid_rst_phasedir", 32'(phasedir), 32'd1);
        tick();
        check("mid_rst_done2", 32'(done), 32'd0);
        reset = 1'b0;
        $display("reset in SETTLE: busy=%0d phasestep=%0d pos=%h", busy, phasestep, phase_pos);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
